rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between two writeback requesters: port 0 (ALU/execute) and port 1 (load unit).
- Keeps a 32-entry pending-write scoreboard so the decode stage can detect read-after-write hazards on the two read addresses.
- Sits between the writeback sources and the register file; its outputs drive we3/a3/wd3 directly.

---
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter with pending-write scoreboard
module rf_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_addr,
  input  logic [XLEN-1:0]  wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_addr,
  input  logic [XLEN-1:0]  wb1_data,
  output logic             wb1_ready,
  input  logic             claim_valid,
  input  logic [4:0]       claim_addr,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic             hazard1,
  output logic             hazard2,
  output logic             rf_we,
  output logic [4:0]       rf_a3,
  output logic [XLEN-1:0]  rf_wd3,
  output logic [CNT_W-1:0] contention_cnt
);

  // One bit per architectural register; bit 0 is never set.
  logic [31:0]     pending;
  // 1 means port 1 won the most recent contested cycle.
  logic            last_grant;
  logic            grant0;
  logic            grant1;
  logic            contest;
  logic [4:0]      g_addr;
  logic [XLEN-1:0] g_data;

  // Grant selection: uncontested requests win outright, contests alternate.
  always_comb begin
    contest = wb0_valid & wb1_valid;
    grant0  = wb0_valid & (~wb1_valid | last_grant);
    grant1  = wb1_valid & (~wb0_valid | ~last_grant);
    g_addr  = grant1 ? wb1_addr : wb0_addr;
    g_data  = grant1 ? wb1_data : wb0_data;
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign hazard1   = pending[ra1];
  assign hazard2   = pending[ra2];

  // Write-port register: one-cycle write pulse per accepted non-x0 transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we  <= 1'b0;
      rf_a3  <= 5'd0;
      rf_wd3 <= '0;
    end else if ((grant0 | grant1) && (g_addr != 5'd0)) begin
      rf_we  <= 1'b1;
      rf_a3  <= g_addr;
      rf_wd3 <= g_data;
    end else begin
      rf_we  <= 1'b0;
    end
  end

  // Round-robin history: only contested cycles move it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (contest) begin
      last_grant <= grant1;
    end
  end

  // Saturating count of cycles where both writers competed.
  always_ff @(posedge clk) begin
    if (reset) begin
      contention_cnt <= '0;
    end else if (contest && (contention_cnt != {CNT_W{1'b1}})) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

  // Scoreboard: a new claim beats a simultaneous retiring write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int r = 1; r < 32; r++) begin
        if (claim_valid && (claim_addr == 5'(r))) begin
          pending[r] <= 1'b1;
        end else if ((grant0 | grant1) && (g_addr == 5'(r))) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb0_valid, wb1_valid, claim_valid;
  logic [4:0]       wb0_addr, wb1_addr, claim_addr, ra1, ra2;
  logic [XLEN-1:0]  wb0_data, wb1_data;
  logic             wb0_ready, wb1_ready, hazard1, hazard2, rf_we;
  logic [4:0]       rf_a3;
  logic [XLEN-1:0]  rf_wd3;
  logic [CNT_W-1:0] contention_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .contention_cnt(contention_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_pend[32];
  int          m_last;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  int          m_cnt;
  bit          g0, g1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_grant();
    if (wb0_valid && wb1_valid) begin
      g0 = (m_last == 1);
      g1 = !g0;
    end else begin
      g0 = wb0_valid;
      g1 = wb1_valid;
    end
  endtask

  task automatic model_edge();
    int a;
    logic [31:0] d;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_last = 1; m_we = 0; m_a3 = 0; m_wd3 = 0; m_cnt = 0;
    end else begin
      if (g0 || g1) begin
        a = g1 ? int'(wb1_addr) : int'(wb0_addr);
        d = g1 ? wb1_data : wb0_data;
        if (a != 0) begin
          m_we = 1; m_a3 = 5'(a); m_wd3 = d;
        end else begin
          m_we = 0;
        end
        m_pend[a] = 0;
      end else begin
        m_we = 0;
      end
      if (claim_valid && claim_addr != 0) m_pend[claim_addr] = 1;
      if (wb0_valid && wb1_valid) begin
        m_last = g1 ? 1 : 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  // One clock: check combinational outputs, advance, check registered outputs.
  task automatic step(input bit chk);
    #1;
    model_grant();
    if (chk) begin
      check("wb0_ready", wb0_ready, g0);
      check("wb1_ready", wb1_ready, g1);
      check("hazard1", hazard1, m_pend[ra1]);
      check("hazard2", hazard2, m_pend[ra2]);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk) begin
      check("rf_we", rf_we, m_we);
      check("rf_a3", rf_a3, m_a3);
      check("rf_wd3", rf_wd3, m_wd3);
      check("contention_cnt", contention_cnt, 64'(m_cnt));
    end
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb1_valid = 0; claim_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(1);
    reset = 0;
  endtask

  bit h0, h1;

  initial begin
    reset = 1; idle_inputs();
    wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
    claim_addr = 0; ra1 = 0; ra2 = 0;
    @(negedge clk);
    do_reset();
    check("reset_we", rf_we, 0);
    check("reset_a3", rf_a3, 0);
    check("reset_wd3", rf_wd3, 0);
    check("reset_cnt", contention_cnt, 0);

    // Single port-0 write
    wb0_valid = 1; wb0_addr = 5; wb0_data = 32'h1C8;
    step(1);
    check("tp1_we", rf_we, 1);
    check("tp1_a3", rf_a3, 5);
    check("tp1_wd3", rf_wd3, 32'h1C8);
    wb0_valid = 0;
    step(1);
    check("tp1_we_drop", rf_we, 0);

    // Alternating contest
    do_reset();
    wb0_valid = 1; wb0_addr = 3; wb0_data = 32'hA;
    wb1_valid = 1; wb1_addr = 4; wb1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("tp2_a3", rf_a3, (i % 2 == 0) ? 3 : 4);
    end
    check("tp2_cnt", contention_cnt, 4);
    idle_inputs();

    // x0 write
    wb1_valid = 1; wb1_addr = 0; wb1_data = 32'hFFFF;
    #1 check("tp3_ready", wb1_ready, 1);
    step(1);
    check("tp3_we", rf_we, 0);
    idle_inputs();

    // Scoreboard
    do_reset();
    claim_valid = 1; claim_addr = 7;
    step(1);
    claim_valid = 0; ra1 = 7;
    #1 check("tp4_haz_set", hazard1, 1);
    wb1_valid = 1; wb1_addr = 7; wb1_data = 32'h77;
    step(1);
    wb1_valid = 0;
    #1 check("tp4_haz_clr", hazard1, 0);
    claim_valid = 1; wb1_valid = 1;
    step(1);
    claim_valid = 0; wb1_valid = 0;
    #1 check("tp4_claim_wins", hazard1, 1);
    step(1);

    // Randomized traffic
    do_reset();
    h0 = 0; h1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!h0) begin
        wb0_valid = ($urandom_range(0, 2) != 0);
        wb0_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wb0_data  = $urandom;
      end
      if (!h1) begin
        wb1_valid = ($urandom_range(0, 2) != 0);
        wb1_addr  = 5'($urandom_range(0, 7));
        wb1_data  = $urandom;
      end
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) == 0);
      step(1);
      h0 = wb0_valid && !g0;
      h1 = wb1_valid && !g1;
    end
    reset = 0;

    // Counter saturation
    do_reset();
    wb0_valid = 1; wb0_addr = 1; wb1_valid = 1; wb1_addr = 2;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step(0);
    check("tp5_sat", contention_cnt, 16'hFFFF);
    idle_inputs();

    // Reset mid-operation
    claim_valid = 1; claim_addr = 2;
    step(1);
    claim_addr = 9;
    step(1);
    claim_valid = 0;
    wb0_valid = 1; wb0_addr = 5; wb0_data = 32'h55;
    step(1);
    check("tp6_we_before", rf_we, 1);
    wb0_valid = 0;
    wb1_valid = 1; wb1_addr = 6; wb1_data = 32'h66;
    reset = 1;
    step(1);
    reset = 0; idle_inputs();
    check("tp6_we", rf_we, 0);
    check("tp6_cnt", contention_cnt, 0);
    ra1 = 2; ra2 = 9;
    #1;
    check("tp6_haz2", hazard1, 0);
    check("tp6_haz9", hazard2, 0);
    wb0_valid = 1; wb1_valid = 1; wb0_addr = 3; wb1_addr = 4;
    #1;
    check("tp6_first_grant0", wb0_ready, 1);
    check("tp6_first_grant1", wb1_ready, 0);
    step(1);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
